rob: RTL

ROB -- requirements
Module: rob

---
 rtl/rob_pkg.sv | 16 +
 rtl/rob.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rob_pkg.sv
// Reorder buffer shared definitions: depth, id width and decoder type codes.
// Imported by the ROB and by the RS, LSB and decoder that exchange ROB ids.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_R     = $clog2(ROB_DEPTH);
  localparam int ROB_A     = ROB_DEPTH - 1;

  typedef enum logic [1:0] {
    T_ALU  = 2'd0,
    T_BR   = 2'd1,
    T_ST   = 2'd2,
    T_JALR = 2'd3
  } dc_type_e;

endpackage

// File: rtl/rob.sv
// In-order reorder buffer: allocates at tail, collects writebacks,
// retires one entry per cycle from head and flushes on redirect.
module rob
  import rob_pkg::*;
#(
  parameter int  ROB_SIZE = ROB_DEPTH,
  localparam int RW       = $clog2(ROB_SIZE)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          dc_valid,
  input  logic [1:0]    dc_type,
  input  logic [4:0]    dc_rd,
  input  logic          dc_pred_taken,
  input  logic [31:0]   dc_alt_pc,
  output logic          rob_full,
  output logic [RW-1:0] rob_tail,
  input  logic          rs_has_output,
  input  logic [RW-1:0] rs_rob_id,
  input  logic [31:0]   rs_output,
  input  logic [31:0]   jalr_new_pc,
  input  logic          is_lsb,
  input  logic [RW-1:0] lsb_rob_id,
  input  logic [31:0]   lsb_res,
  input  logic [RW-1:0] qry1_id,
  input  logic [RW-1:0] qry2_id,
  output logic          qry1_ready,
  output logic [31:0]   qry1_value,
  output logic          qry2_ready,
  output logic [31:0]   qry2_value,
  output logic          commit_valid,
  output logic [4:0]    commit_rd,
  output logic [31:0]   commit_value,
  output logic [RW-1:0] commit_rob_id,
  output logic          commit_store,
  output logic          rob_clear,
  output logic [31:0]   clear_pc
);

  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_ready;
  dc_type_e            r_type [ROB_SIZE];
  logic [4:0]          r_rd   [ROB_SIZE];
  logic                r_pred [ROB_SIZE];
  logic [31:0]         r_alt  [ROB_SIZE];
  logic [31:0]         r_val  [ROB_SIZE];
  logic [31:0]         r_npc  [ROB_SIZE];
  logic [RW-1:0]       r_head;
  logic [RW-1:0]       r_tail;
  logic [RW:0]         r_count;

  dc_type_e    w_htype;
  logic        w_full;
  logic        w_commit;
  logic        w_clr;
  logic        w_alloc;
  logic [RW:0] w_cnt_nxt;

  assign w_htype  = r_type[r_head];
  assign w_full   = (r_count == (RW+1)'(ROB_SIZE));
  assign rob_full = w_full;
  assign rob_tail = r_tail;

  always_comb begin
    w_commit  = rdy_in & r_busy[r_head] & r_ready[r_head];
    w_clr     = w_commit &
                ((w_htype == T_JALR) |
                 ((w_htype == T_BR) &
                  (r_val[r_head][0] != r_pred[r_head])));
    // A full buffer still accepts an entry when the head retires this edge
    w_alloc   = rdy_in & dc_valid & (~w_full | w_commit) & ~w_clr;
    w_cnt_nxt = r_count;
    if (w_alloc && !w_commit)
      w_cnt_nxt = r_count + (RW+1)'(1);
    else if (!w_alloc && w_commit)
      w_cnt_nxt = r_count - (RW+1)'(1);
  end

  function automatic logic [32:0] lookup(input logic [RW-1:0] id);
    lookup = '0;
    if (r_busy[id]) begin
      if (r_ready[id])
        lookup = {1'b1, r_val[id]};
      else if (rs_has_output && rs_rob_id == id)
        lookup = {1'b1, rs_output};
      else if (is_lsb && lsb_rob_id == id)
        lookup = {1'b1, lsb_res};
    end
  endfunction

  assign {qry1_ready, qry1_value} = lookup(qry1_id);
  assign {qry2_ready, qry2_value} = lookup(qry2_id);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy        <= '0;
      r_ready       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      commit_valid  <= 1'b0;
      commit_rd     <= '0;
      commit_value  <= '0;
      commit_rob_id <= '0;
      commit_store  <= 1'b0;
      rob_clear     <= 1'b0;
      clear_pc      <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_type[i] <= T_ALU;
        r_rd[i]   <= '0;
        r_pred[i] <= 1'b0;
        r_alt[i]  <= '0;
        r_val[i]  <= '0;
        r_npc[i]  <= '0;
      end
    end else begin
      commit_valid <= 1'b0;
      rob_clear    <= 1'b0;
      if (w_commit) begin
        commit_valid     <= 1'b1;
        commit_rob_id    <= r_head;
        commit_value     <= r_val[r_head];
        commit_store     <= (w_htype == T_ST);
        commit_rd        <= (w_htype == T_ST || w_htype == T_BR)
                            ? 5'd0 : r_rd[r_head];
        r_busy[r_head]   <= 1'b0;
        r_ready[r_head]  <= 1'b0;
      end
      if (w_clr) begin
        rob_clear <= 1'b1;
        clear_pc  <= (w_htype == T_JALR)
                     ? r_npc[r_head] : r_alt[r_head];
        r_busy    <= '0;
        r_ready   <= '0;
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
      end else if (rdy_in) begin
        if (rs_has_output && r_busy[rs_rob_id]) begin
          r_ready[rs_rob_id] <= 1'b1;
          r_val[rs_rob_id]   <= rs_output;
          r_npc[rs_rob_id]   <= jalr_new_pc;
        end
        if (is_lsb && r_busy[lsb_rob_id]) begin
          r_ready[lsb_rob_id] <= 1'b1;
          r_val[lsb_rob_id]   <= lsb_res;
        end
        if (w_commit)
          r_head <= r_head + RW'(1);
        if (w_alloc) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= (dc_type_e'(dc_type) == T_ST);
          r_type[r_tail]  <= dc_type_e'(dc_type);
          r_rd[r_tail]    <= dc_rd;
          r_pred[r_tail]  <= dc_pred_taken;
          r_alt[r_tail]   <= dc_alt_pc;
          r_val[r_tail]   <= '0;
          r_npc[r_tail]   <= '0;
          r_tail          <= r_tail + RW'(1);
        end
        r_count <= w_cnt_nxt;
      end
    end
  end

endmodule
